capture_seq: RTL

Sample-capture sequencer that sits directly upstream of the signal-generator delay RAM. It accepts audio samples over a valid/ready handshake and drives the RAM's write strobe, read strobe, write address and write data. It steps the write address by a programmable increment with wrap-around and supports circular (continuous) and one-shot capture modes. It reports fill level and completion to the top level.

---
 rtl/capture_seq_pkg.sv | 13 +
 rtl/capture_seq_if.sv | 25 ++
 rtl/capture_seq_addr_step.sv | 38 +++
 rtl/capture_seq.sv | 117 +++++++++++
 4 files changed

// File: rtl/capture_seq_pkg.sv
// Shared types and constants for the sample-capture sequencer.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_CIRCULAR = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/capture_seq_if.sv
// Sample handshake from upstream and write port toward the delay RAM.
interface capture_seq_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
);

  logic                     sample_valid;
  logic [DATA_WIDTH-1:0]    sample;
  logic                     sample_ready;
  logic                     wr;
  logic                     rd;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]    din;

  modport master (
    output sample_valid, sample,
    input  sample_ready, wr, rd, wr_addr, din
  );

  modport slave (
    input  sample_valid, sample,
    output sample_ready, wr, rd, wr_addr, din
  );

endinterface

// File: rtl/capture_seq_addr_step.sv
// Write pointer that advances by a programmable step and wraps at the RAM depth.
module addr_step #(
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     step_en_i,
  input  logic [ADDRESS_WIDTH-1:0] incr_i,
  output logic [ADDRESS_WIDTH-1:0] ptr_o
);

  logic [ADDRESS_WIDTH-1:0] ptr_q;
  logic [ADDRESS_WIDTH-1:0] ptr_d;
  logic [ADDRESS_WIDTH-1:0] stepAmt;

  // A zero step would freeze the pointer, so it is promoted to one; the sum wraps naturally.
  always_comb begin
    stepAmt = (incr_i == '0) ? ADDRESS_WIDTH'(1) : incr_i;
    ptr_d   = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (step_en_i) begin
      ptr_d = ptr_q + stepAmt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/capture_seq.sv
// Capture sequencer: accepts samples and issues registered writes into the delay RAM,
// in circular or one-shot mode, reporting fill level and completion.
module capture_seq
  import capture_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     mode_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [ADDRESS_WIDTH-1:0] incr_i,
  capture_seq_if.slave             bus,
  output logic [ADDRESS_WIDTH:0]   fill_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam logic [ADDRESS_WIDTH:0] DEPTH = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  state_t                   state_q;
  state_t                   state_d;
  logic [ADDRESS_WIDTH:0]   fill_q;
  logic [ADDRESS_WIDTH:0]   fill_d;
  logic [ADDRESS_WIDTH:0]   fillInc;
  logic                     strobe_q;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0]    din_q;
  logic [ADDRESS_WIDTH-1:0] ptr;
  logic                     acceptNow;
  logic                     clrPtr;

  assign bus.sample_ready = (state_q == RUN) && en_i && !abort_i;
  assign acceptNow        = bus.sample_valid && bus.sample_ready;
  assign fillInc          = (fill_q == DEPTH) ? fill_q : fill_q + (ADDRESS_WIDTH + 1)'(1);

  // With en low nothing moves; abort always beats start, and start inside RUN is ignored.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    clrPtr  = 1'b0;
    if (en_i) begin
      case (state_q)
        IDLE: begin
          if (start_i && !abort_i) begin
            state_d = RUN;
            clrPtr  = 1'b1;
          end
        end
        RUN: begin
          if (abort_i) begin
            state_d = IDLE;
          end else if (acceptNow) begin
            fill_d = fillInc;
            if (mode_i == MODE_ONESHOT && fillInc == DEPTH) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (abort_i) begin
            state_d = IDLE;
          end else if (start_i) begin
            state_d = RUN;
            clrPtr  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (clrPtr) begin
      fill_d = '0;
    end
  end

  addr_step #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_addr_step (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clrPtr),
    .step_en_i(acceptNow),
    .incr_i   (incr_i),
    .ptr_o    (ptr)
  );

  // The RAM sees each accepted sample one cycle later at the pre-step pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      fill_q    <= '0;
      strobe_q  <= 1'b0;
      wr_addr_q <= '0;
      din_q     <= '0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      strobe_q <= acceptNow;
      if (acceptNow) begin
        wr_addr_q <= ptr;
        din_q     <= bus.sample;
      end
    end
  end

  assign bus.wr      = strobe_q;
  assign bus.rd      = strobe_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.din     = din_q;
  assign fill_o      = fill_q;
  assign busy_o      = (state_q == RUN);
  assign done_o      = (state_q == DONE);

endmodule
